// File: rtl/demux_sweep_sched.sv
// demux_sweep_sched: round-robin dwell/gap sequencer driving a 1-to-8 demux select and data bit.
// Define DEMUX_SWEEP_LIVE_MASK_EN to re-sample ch_en at every channel seek instead of latching it at start.
module demux_sweep_sched #(
  parameter int DWELL_W    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         ch_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               din,
  output logic [2:0]         sel,
  output logic               dmx_i,
  output logic               dmx_valid,
  output logic               busy,
  output logic               frame_done,
  output logic [CNT_W-1:0]   sweep_cnt,
  output logic               err_empty
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEEK  = 2'd1;
  localparam logic [1:0] DWELL = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]         state_q, state_d;
  logic [2:0]         sel_q, sel_d, ptr_q, ptr_d, nxt, top;
  logic [7:0]         mask_q, mask_d, seek_mask;
  logic [DWELL_W-1:0] len_q, len_d, dcnt_q, dcnt_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               stop_q, stop_d, fd_q, fd_d, err_q, err_d;
  logic               valid_q, valid_d, dmx_q, dmx_d, busy_q, busy_d;
  logic               found, seek_empty, stop_hit, last;

`ifdef DEMUX_SWEEP_LIVE_MASK_EN
  assign seek_mask  = ch_en;
  assign seek_empty = ch_en == 8'd0;
`else
  assign seek_mask  = mask_q;
  assign seek_empty = 1'b0;
`endif

  assign stop_hit = stop_q | stop;
  assign last     = ptr_q == top;

  // nxt: first enabled channel strictly after ptr, wrapping; top: highest enabled channel of the sweep mask
  always_comb begin
    nxt   = ptr_q;
    found = 1'b0;
    top   = 3'd0;
    for (int i = 1; i <= 8; i++)
      if (!found && seek_mask[ptr_q + 3'(i)]) begin
        nxt   = ptr_q + 3'(i);
        found = 1'b1;
      end
    for (int i = 0; i < 8; i++)
      if (mask_q[i]) top = 3'(i);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    mask_d  = mask_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    gcnt_d  = gcnt_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q | (stop && state_q != IDLE);
    fd_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:
        if (start) begin
          if (ch_en == 8'd0) err_d = 1'b1;
          else begin
            mask_d  = ch_en;
            len_d   = (dwell == '0) ? DWELL_W'(1) : dwell;
            state_d = SEEK;
          end
        end
      SEEK: begin
        mask_d = seek_mask;
        if (seek_empty) begin
          err_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sel_d   = nxt;
          ptr_d   = nxt;
          dcnt_d  = len_q - 1'b1;
          state_d = DWELL;
        end
      end
      DWELL:
        if (dcnt_q != '0) dcnt_d = dcnt_q - 1'b1;
        else begin
          if (last) begin
            fd_d  = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
          if (stop_hit) begin
            stop_d  = 1'b0;
            state_d = IDLE;
          end else if (GAP_CYCLES > 0) begin
            gcnt_d  = GW'(GAP_CYCLES - 1);
            state_d = GAP;
          end else state_d = SEEK;
        end
      GAP:
        if (gcnt_q != '0) gcnt_d = gcnt_q - 1'b1;
        else begin
          stop_d  = 1'b0;
          state_d = stop_hit ? IDLE : SEEK;
        end
      default: state_d = IDLE;
    endcase
    valid_d = state_d == DWELL;
    dmx_d   = (state_d == DWELL) & din;
    busy_d  = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd7;
      mask_q  <= 8'd0;
      len_q   <= DWELL_W'(1);
      dcnt_q  <= '0;
      gcnt_q  <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      dmx_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      dcnt_q  <= dcnt_d;
      gcnt_q  <= gcnt_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      dmx_q   <= dmx_d;
      busy_q  <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign dmx_i      = dmx_q;
  assign dmx_valid  = valid_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign sweep_cnt  = cnt_q;
  assign err_empty  = err_q;
endmodule

// File: tb/tb_demux_sweep_sched.sv
// tb_demux_sweep_sched: random and directed sweeps checked against a timeline model of channel visits.
module tb_demux_sweep_sched;
  localparam int GAP = 1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, din = 1'b0;
  logic [7:0] ch_en = 8'd0;
  logic [3:0] dwell = 4'd0;
  logic [2:0] sel;
  logic dmx_i, dmx_valid, busy, frame_done, err_empty;
  logic [7:0] sweep_cnt;
  int checks = 0, errors = 0;
  int m_busy, m_k, m_end, m_d, m_cnt;
  logic [7:0] m_mask;
  logic [2:0] m_ptr, m_sel;
  logic e_valid, e_dmx, e_fd, e_err;

  demux_sweep_sched #(.DWELL_W(4), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ch_en(ch_en), .dwell(dwell), .din(din),
    .sel(sel), .dmx_i(dmx_i), .dmx_valid(dmx_valid), .busy(busy), .frame_done(frame_done),
    .sweep_cnt(sweep_cnt), .err_empty(err_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] next_ch(input logic [2:0] p, input logic [7:0] m);
    for (int i = 1; i <= 8; i++)
      if (m[(int'(p) + i) % 8]) return 3'((int'(p) + i) % 8);
    return p;
  endfunction

  function automatic int top_ch(input logic [7:0] m);
    for (int i = 7; i >= 0; i--)
      if (m[i]) return i;
    return -1;
  endfunction

  // Cycle k of a run sits at offset k % (1+dwell+GAP) of a visit: 0 = seek, 1..dwell = driven, rest = gap.
  task automatic model_edge();
    int p, o;
    e_fd = 1'b0;
    e_err = 1'b0;
    if (m_busy == 0) begin
      if (start) begin
        if (ch_en == 8'd0) e_err = 1'b1;
        else begin
          m_busy = 1; m_mask = ch_en; m_d = (dwell == 4'd0) ? 1 : int'(dwell); m_k = 0; m_end = -1;
        end
      end
    end else begin
      p = 1 + m_d + GAP;
      o = m_k % p;
      if (stop && m_end < 0) m_end = (o <= m_d) ? m_k - o + m_d + 1 : m_k - o + p;
      if (o == 0) begin
`ifdef DEMUX_SWEEP_LIVE_MASK_EN
        m_mask = ch_en;
`endif
        if (m_mask == 8'd0) begin
          e_err = 1'b1;
          m_busy = 0;
        end else begin
          m_ptr = next_ch(m_ptr, m_mask);
          m_sel = m_ptr;
        end
      end
      if (m_busy != 0 && o == m_d && int'(m_ptr) == top_ch(m_mask)) begin
        e_fd = 1'b1;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (m_busy != 0) begin
        m_k++;
        if (m_k == m_end) m_busy = 0;
      end
    end
    e_valid = 1'b0;
    if (m_busy != 0) begin
      p = 1 + m_d + GAP;
      o = m_k % p;
      e_valid = (o >= 1 && o <= m_d);
    end
    e_dmx = e_valid & din;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sel", 32'(sel), 32'(m_sel));
    chk("valid", 32'(dmx_valid), 32'(e_valid));
    chk("dmx_i", 32'(dmx_i), 32'(e_dmx));
    chk("busy", 32'(busy), 32'(m_busy != 0));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("sweep_cnt", 32'(sweep_cnt), 32'(m_cnt));
    chk("err_empty", 32'(err_empty), 32'(e_err));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    start = 1'b0; stop = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(dmx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(sweep_cnt), 0);
    chk("rst_fd_err_dmx", {29'd0, frame_done, err_empty, dmx_i}, 0);
    m_busy = 0; m_ptr = 3'd7; m_sel = 3'd0; m_cnt = 0; m_end = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run(input logic [7:0] mask, input logic [3:0] dw, input int stop_at, input int len, input bit rnd);
    int n;
    ch_en = mask; dwell = dw; start = 1'b1; din = 1'($urandom);
    step();
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      din = 1'($urandom);
      stop = (i == stop_at) && (m_busy != 0);
      start = rnd && ($urandom_range(0, 15) == 0);
      if (rnd && $urandom_range(0, 9) == 0) ch_en = 8'($urandom);
      if (rnd && $urandom_range(0, 7) == 0) dwell = 4'($urandom);
      step();
    end
    start = 1'b0;
    stop = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(busy), 0);
    stop = 1'b0;
    step();
  endtask

  initial begin
    m_busy = 0; m_ptr = 3'd7; m_sel = 3'd0; m_cnt = 0; m_end = -1; m_d = 1; m_k = 0; m_mask = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ch_en = 8'h08; dwell = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("ch3_dwell_sel", 32'(sel), 3);
    do_reset();
    run(8'h08, 4'd2, -1, 8, 1'b0);
    run(8'h05, 4'd2, -1, 40, 1'b0);
    run(8'h80, 4'd0, -1, 20, 1'b0);
    run(8'h00, 4'd1, -1, 4, 1'b0);
    do_reset();
    run(8'hFF, 4'd3, 22, 30, 1'b0);
    run(8'hFF, 4'd3, -1, 6, 1'b0);
    run(8'h03, 4'd2, -1, 30, 1'b0);
    for (int e = 0; e < 40; e++) begin
      if (e % 13 == 7) do_reset();
      run(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom), 4'($urandom), $urandom_range(0, 1) ? int'($urandom_range(0, 60)) : -1,
          $urandom_range(20, 80), 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_sweep_sched.md
Name: demux_sweep_sched

Overview:
- Sequencer for the team's 1-to-8 demultiplexer (1-bit input, 3-bit select, outputs y0..y7).
- Owns the demux select and data input. Sweeps round-robin through a programmable set of enabled output channels.
- Holds each channel for a programmable dwell time, inserts guard gaps, and reports sweep completion.
- Sits between control logic (start/stop, channel mask) and the demux instance.

Parameters:
- DWELL_W, 4, width of dwell-length input; dwell range 1..2^DWELL_W-1 cycles.
- GAP_CYCLES, 1, idle cycles inserted after each dwell (0 = no gap state).
- CNT_W, 8, width of sweep counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweeping; sampled only in IDLE
- stop  input  1  request halt; level or pulse, latched until honoured
- ch_en  input  8  channel enable mask, bit k = demux output yk
- dwell  input  DWELL_W  cycles per channel visit; 0 treated as 1
- din  input  1  data bit forwarded to demux during dwell
- sel  output  3  demux select
- dmx_i  output  1  demux data input
- dmx_valid  output  1  high while a channel is being driven
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse at end of each full sweep
- sweep_cnt  output  CNT_W  completed-sweep count, wraps modulo 2^CNT_W
- err_empty  output  1  one-cycle pulse when start is seen with ch_en == 0

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low. All outputs and state are registered.
- Reset values: state=IDLE, sel=0, dmx_i=0, dmx_valid=0, busy=0, frame_done=0, sweep_cnt=0, err_empty=0, ptr=7, stop latch=0. Reset asserted mid-sweep forces these values immediately, with no completion of the current dwell.
- States: IDLE, SEEK, DWELL, GAP.
- IDLE:
  - start with ch_en != 0: latch mask and dwell (0 becomes 1), go to SEEK.
  - start with ch_en == 0: pulse err_empty, stay IDLE.
  - sweep_cnt is not cleared by start; only reset clears it.
- SEEK (exactly 1 cycle):
  - Select the first enabled channel strictly after ptr, searching round-robin and wrapping 7 -> 0.
  - Load sel and ptr with it, load dwell counter, go to DWELL. dmx_valid=0.
  - Single-bit mask: the same channel is reselected every visit.
- DWELL (exactly dwell cycles): dmx_valid=1, dmx_i=din (registered, one cycle latency from din), sel held.
- End of DWELL:
  - If ptr is the highest set bit of the latched mask: pulse frame_done and increment sweep_cnt in the final DWELL cycle's next edge (same cycle as the transition).
  - Next state:
    - stop latch set: go to IDLE and clear the latch.
    - else GAP_CYCLES > 0: go to GAP.
    - else: go to SEEK.
- GAP (GAP_CYCLES cycles): dmx_valid=0, dmx_i=0, sel held; then SEEK. A stop seen in GAP goes to IDLE at gap end.
- Stop timing: stop is honoured only at dwell or gap boundaries; an in-progress dwell always completes.
- Start while busy: ignored.
- Leaving to IDLE: ptr keeps its value, so a later start resumes after the last channel served. Reset returns ptr to 7 (next sweep begins at channel 0).
- Channel period: 1 + dwell + GAP_CYCLES cycles per visited channel.

Optional Feature:
- Macro: DEMUX_SWEEP_LIVE_MASK_EN.
- Defined:
  - ch_en is re-sampled in every SEEK cycle instead of being latched at start. frame_done uses the mask sampled in that SEEK.
  - If the sampled mask is 0 in SEEK: pulse err_empty and go to IDLE.
- Undefined: mask latched at start only; ch_en changes during a sweep have no effect until the next start.

Test Plan:
- Reset mid-DWELL on channel 3 -> next cycle sel=0, dmx_valid=0, busy=0, sweep_cnt=0; after release, start with ch_en=0x08 -> sel=3.
- ch_en=0x05, dwell=2, GAP_CYCLES=1, start, din=1 -> repeating pattern:
  - sel=0, valid 2 cycles; 2 cycles invalid; sel=2, valid 2 cycles.
  - frame_done pulses after channel 2's dwell; sweep_cnt 0->1->2 on consecutive sweeps (period 8 cycles).
- ch_en=0x80, dwell=0 -> sel=7 every visit, valid 1 cycle per 3-cycle period, frame_done every visit.
- Start with ch_en=0x00 -> err_empty pulses 1 cycle, busy stays 0.
- ch_en=0xFF, dwell=3, stop asserted in 2nd cycle of channel 4 dwell -> channel 4 completes 3 valid cycles, then IDLE. Restart -> first sel=5.
- LIVE_MASK build: ch_en=0x03 running, change to 0x00 during dwell -> next SEEK pulses err_empty and enters IDLE. Latched build: sweep continues on channels 0,1.
